// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM length-block tracker.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package gcm_pkg;

  // Tracker phases: waiting, counting AAD, counting CT, presenting length block
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AAD  = 2'd1,
    ST_CT   = 2'd2,
    ST_EMIT = 2'd3
  } gcm_state_e;

  // Supported data-path widths in bytes per beat
  localparam int BEAT_BYTES_W4  = 4;
  localparam int BEAT_BYTES_W8  = 8;
  localparam int BEAT_BYTES_W16 = 16;

  // SP 800-38D plaintext/ciphertext limit: 2^36 - 32 bytes
  localparam logic [63:0] CT_MAX_BYTES_DFLT = 64'h0000_000F_FFFF_FFE0;

  // Length fields are between 32 and 64 bits wide
  localparam int LEN_W_MIN = 32;
  localparam int LEN_W_MAX = 64;

  function automatic logic beat_bytes_legal(input int b);
    return (b == BEAT_BYTES_W4) || (b == BEAT_BYTES_W8) || (b == BEAT_BYTES_W16);
  endfunction

  function automatic logic len_w_legal(input int w);
    return (w >= LEN_W_MIN) && (w <= LEN_W_MAX);
  endfunction

endpackage

// File: rtl/gcm_sat_cnt.sv
// Saturating byte counter: clears, adds an increment, clamps at MAX and flags the clamp.
// Latency: count visible one cycle after the increment; cnt_nxt shows the pending value.
// Backpressure: none; the caller gates inc_en.
module gcm_sat_cnt #(
  parameter int             W   = 61,
  parameter int             IW  = 5,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc_en,
  input  logic [IW-1:0] inc_val,
  output logic [W-1:0]  cnt_nxt,
  output logic          ovf
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   inc_ext;
  logic [W:0]   sum;

  // Next count: clear wins, otherwise add and clamp at MAX instead of wrapping
  always_comb begin
    inc_ext          = '0;
    inc_ext[IW-1:0]  = inc_val;
    sum              = {1'b0, cnt_q} + inc_ext;
    cnt_d            = cnt_q;
    ovf              = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc_en) begin
      if (sum > {1'b0, MAX}) begin
        cnt_d = MAX;
        ovf   = 1'b1;
      end else begin
        cnt_d = sum[W-1:0];
      end
    end
  end

  assign cnt_nxt = cnt_d;

  // Count register, assigned every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcm_len_tracker.sv
// Counts AAD and CT bytes of one GCM message and emits the final {aad_bits, ct_bits} block.
// Latency: len_valid rises exactly one cycle after finish; block returns to IDLE one cycle after handshake.
// Backpressure: len_block/len_valid held until len_ready; beats are never stalled, protocol faults set err.
module gcm_len_tracker
  import gcm_pkg::*;
#(
  parameter int          BEAT_BYTES   = 16,
  parameter int          LEN_W        = 64,
  parameter logic [63:0] CT_MAX_BYTES = CT_MAX_BYTES_DFLT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          aad_valid,
  input  logic                          ct_valid,
  input  logic [$clog2(BEAT_BYTES):0]   beat_bytes,
  input  logic                          finish,
  output logic                          len_valid,
  input  logic                          len_ready,
  output logic [2*LEN_W-1:0]            len_block,
  output logic                          busy,
  output logic                          err
);

  localparam int BB_W  = $clog2(BEAT_BYTES) + 1;
  // Byte counters are 3 bits narrower so that bytes<<3 fits a length field
  localparam int CNT_W = LEN_W - 3;
  localparam logic [63:0]     AAD_MAX64 = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0]     CT_LIM64  = (CT_MAX_BYTES < AAD_MAX64) ? CT_MAX_BYTES : AAD_MAX64;
  localparam logic [BB_W-1:0] BEAT_MAX  = BB_W'(BEAT_BYTES);

  if (!beat_bytes_legal(BEAT_BYTES) || !len_w_legal(LEN_W)) begin : g_param_chk
    $error("gcm_len_tracker: BEAT_BYTES must be 4/8/16 and LEN_W 32..64");
  end

  gcm_state_e          state_q, state_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                len_valid_q, len_valid_d;
  logic [2*LEN_W-1:0]  len_block_q, len_block_d;
  logic                aad_closed_q, aad_closed_d;
  logic                ct_closed_q, ct_closed_d;

  logic                cnt_clr;
  logic                aad_inc, ct_inc;
  logic                aad_close, ct_close;
  logic                beat_err;
  logic                beat_ok, beat_short;
  logic                counting;
  logic [CNT_W-1:0]    aad_nxt, ct_nxt;
  logic                aad_ovf, ct_ovf;

  assign counting   = (state_q == ST_AAD) || (state_q == ST_CT);
  assign beat_ok    = (beat_bytes != '0) && (beat_bytes <= BEAT_MAX);
  assign beat_short = (beat_bytes < BEAT_MAX);

  // Classify this cycle's beat: count it, close its phase, or flag a protocol error
  always_comb begin
    cnt_clr   = 1'b0;
    aad_inc   = 1'b0;
    ct_inc    = 1'b0;
    aad_close = 1'b0;
    ct_close  = 1'b0;
    beat_err  = 1'b0;
    if (start && (counting || (state_q == ST_IDLE))) begin
      cnt_clr = 1'b1;
    end else if (counting) begin
      if (aad_valid && ct_valid) begin
        beat_err = 1'b1;
      end else if (aad_valid) begin
        if (!beat_ok || (state_q == ST_CT) || aad_closed_q) begin
          beat_err = 1'b1;
        end else begin
          aad_inc   = 1'b1;
          aad_close = beat_short;
        end
      end else if (ct_valid) begin
        if (!beat_ok || ct_closed_q) begin
          beat_err = 1'b1;
        end else begin
          ct_inc   = 1'b1;
          ct_close = beat_short;
        end
      end
    end
  end

  gcm_sat_cnt #(
    .W   (CNT_W),
    .IW  (BB_W),
    .MAX (AAD_MAX64[CNT_W-1:0])
  ) u_aad_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc_en  (aad_inc),
    .inc_val (beat_bytes),
    .cnt_nxt (aad_nxt),
    .ovf     (aad_ovf)
  );

  gcm_sat_cnt #(
    .W   (CNT_W),
    .IW  (BB_W),
    .MAX (CT_LIM64[CNT_W-1:0])
  ) u_ct_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc_en  (ct_inc),
    .inc_val (beat_bytes),
    .cnt_nxt (ct_nxt),
    .ovf     (ct_ovf)
  );

  // Phase sequencing; the length block is captured from the post-beat counts on finish
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    aad_closed_d = aad_closed_q;
    ct_closed_d  = ct_closed_q;
    len_valid_d  = len_valid_q;
    len_block_d  = len_block_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_AAD;
          err_d        = 1'b0;
          aad_closed_d = 1'b0;
          ct_closed_d  = 1'b0;
        end
      end
      ST_AAD, ST_CT: begin
        if (start) begin
          state_d      = ST_AAD;
          err_d        = 1'b0;
          aad_closed_d = 1'b0;
          ct_closed_d  = 1'b0;
        end else begin
          err_d = err_q | beat_err | aad_ovf | ct_ovf;
          if (aad_close) aad_closed_d = 1'b1;
          if (ct_close)  ct_closed_d  = 1'b1;
          if (ct_inc)    state_d      = ST_CT;
          if (finish) begin
            state_d     = ST_EMIT;
            len_valid_d = 1'b1;
            len_block_d = {aad_nxt, 3'b000, ct_nxt, 3'b000};
          end
        end
      end
      ST_EMIT: begin
        if (len_ready) begin
          state_d     = ST_IDLE;
          len_valid_d = 1'b0;
          len_block_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      len_valid_q  <= 1'b0;
      len_block_q  <= '0;
      aad_closed_q <= 1'b0;
      ct_closed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      len_valid_q  <= len_valid_d;
      len_block_q  <= len_block_d;
      aad_closed_q <= aad_closed_d;
      ct_closed_q  <= ct_closed_d;
    end
  end

  assign len_valid = len_valid_q;
  assign len_block = len_block_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gcm_len_tracker.sv
// Bench for gcm_len_tracker: directed message sequences against a byte-count model.
// Latency: n/a.
// Backpressure: len_ready driven per vector.
module tb_gcm_len_tracker;

  localparam int BB  = 16;
  localparam int BBW = 5;
  localparam longint unsigned AAD_LIM = (64'd1 << 61) - 64'd1;
  localparam longint unsigned CT_LIM  = 64'h0000_000F_FFFF_FFE0;
  localparam longint unsigned CT_PRE  = 64'h0000_000F_FFFF_FFD8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           aad_valid = 1'b0;
  logic           ct_valid = 1'b0;
  logic [BBW-1:0] beat_bytes = '0;
  logic           finish = 1'b0;
  logic           len_ready = 1'b0;
  logic           len_valid;
  logic [127:0]   len_block;
  logic           busy;
  logic           err;

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;
  bit preload_req = 1'b0;

  always #5 clk = ~clk;

  gcm_len_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .aad_valid  (aad_valid),
    .ct_valid   (ct_valid),
    .beat_bytes (beat_bytes),
    .finish     (finish),
    .len_valid  (len_valid),
    .len_ready  (len_ready),
    .len_block  (len_block),
    .busy       (busy),
    .err        (err)
  );

  task automatic cmp(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 aad, 2 ct, 3 emit; byte totals kept as plain integers
  int              m_ph;
  longint unsigned m_aad, m_ct;
  bit              m_err, m_aad_done, m_ct_done;

  task automatic m_new_msg();
    m_aad = 0; m_ct = 0; m_err = 0; m_aad_done = 0; m_ct_done = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0;
      m_new_msg();
    end else begin
      if (preload_req) m_ct = CT_PRE;
      case (m_ph)
        0: if (start) begin m_new_msg(); m_ph = 1; end
        1, 2: begin
          if (start) begin
            m_new_msg();
            m_ph = 1;
          end else begin
            if (aad_valid && ct_valid) m_err = 1;
            else if (aad_valid) begin
              if (beat_bytes == 0 || beat_bytes > BB || m_ph == 2 || m_aad_done) m_err = 1;
              else begin
                m_aad += beat_bytes;
                if (beat_bytes < BB) m_aad_done = 1;
                if (m_aad > AAD_LIM) begin m_aad = AAD_LIM; m_err = 1; end
              end
            end else if (ct_valid) begin
              if (beat_bytes == 0 || beat_bytes > BB || m_ct_done) m_err = 1;
              else begin
                m_ct += beat_bytes;
                m_ph = 2;
                if (beat_bytes < BB) m_ct_done = 1;
                if (m_ct > CT_LIM) begin m_ct = CT_LIM; m_err = 1; end
              end
            end
            if (finish) m_ph = 3;
          end
        end
        default: if (len_ready) m_ph = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("len_valid", {127'd0, len_valid}, {127'd0, (m_ph == 3)});
      cmp("busy", {127'd0, busy}, {127'd0, (m_ph != 0)});
      cmp("err", {127'd0, err}, {127'd0, m_err});
      if (m_ph == 3) cmp("len_block", len_block, {m_aad * 64'd8, m_ct * 64'd8});
    end
  end

  task automatic drv(input bit s, input bit a, input bit c, input int bb, input bit f, input bit r);
    start = s; aad_valid = a; ct_valid = c; beat_bytes = bb[BBW-1:0]; finish = f; len_ready = r;
    @(posedge clk); #1;
    start = 0; aad_valid = 0; ct_valid = 0; beat_bytes = '0; finish = 0; len_ready = 0;
  endtask

  task automatic idle(); drv(0, 0, 0, 0, 0, 0); endtask
  task automatic go();   drv(1, 0, 0, 0, 0, 0); endtask
  task automatic fin();  drv(0, 0, 0, 0, 1, 0); endtask
  task automatic ack();  drv(0, 0, 0, 0, 0, 1); endtask
  task automatic ab(input int bb); drv(0, 1, 0, bb, 0, 0); endtask
  task automatic cb(input int bb); drv(0, 0, 1, bb, 0, 0); endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    cmp("rst_len_valid", {127'd0, len_valid}, 128'd0);
    cmp("rst_busy", {127'd0, busy}, 128'd0);
    cmp("rst_err", {127'd0, err}, 128'd0);
    cmp("rst_len_block", len_block, 128'd0);
    @(negedge clk); rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    // Beats in IDLE are ignored
    ab(16); cb(16); fin();
    cmp("idle_ignore_busy", {127'd0, busy}, 128'd0);

    // Nominal message: 36 AAD bytes, 48 CT bytes
    go(); ab(16); ab(16); ab(4); cb(16); cb(16); cb(16); fin();
    cmp("nominal_valid", {127'd0, len_valid}, 128'd1);
    cmp("nominal_block", len_block, {64'd288, 64'd384});
    cmp("nominal_err", {127'd0, err}, 128'd0);
    ack();
    cmp("nominal_idle", {127'd0, busy}, 128'd0);

    // Empty message with held-off consumer
    go(); fin();
    cmp("empty_valid", {127'd0, len_valid}, 128'd1);
    cmp("empty_block", len_block, 128'd0);
    for (int i = 0; i < 5; i++) begin
      idle();
      cmp("empty_hold_valid", {127'd0, len_valid}, 128'd1);
      cmp("empty_hold_block", len_block, 128'd0);
    end
    ack();
    cmp("empty_done_valid", {127'd0, len_valid}, 128'd0);
    cmp("empty_done_busy", {127'd0, busy}, 128'd0);

    // AAD after CT
    go(); cb(16); ab(16); fin();
    cmp("aad_after_ct_err", {127'd0, err}, 128'd1);
    cmp("aad_after_ct_block", len_block, {64'd0, 64'd128});
    ack();

    // AAD beat after a short AAD beat
    go(); ab(8); ab(16); fin();
    cmp("aad_closed_err", {127'd0, err}, 128'd1);
    cmp("aad_closed_block", len_block, {64'd64, 64'd0});
    ack();

    // Both valids together, then illegal sizes 0 and 17
    go(); drv(0, 1, 1, 16, 0, 0); fin();
    cmp("dual_valid_block", len_block, 128'd0);
    cmp("dual_valid_err", {127'd0, err}, 128'd1);
    ack();
    go(); ab(0); cb(17); cb(8); fin();
    cmp("bad_size_block", len_block, {64'd0, 64'd64});
    cmp("bad_size_err", {127'd0, err}, 128'd1);
    ack();

    // Beat with finish counted; start and beats ignored in EMIT
    go(); ab(16); drv(0, 0, 1, 12, 1, 0);
    drv(1, 0, 1, 16, 1, 0);
    cmp("emit_ignore_valid", {127'd0, len_valid}, 128'd1);
    cmp("emit_ignore_block", len_block, {64'd128, 64'd96});
    ack();

    // Abort mid-message clears counts and err
    go(); ab(16); cb(16); ab(16); go(); ab(4); fin();
    cmp("abort_err", {127'd0, err}, 128'd0);
    cmp("abort_block", len_block, {64'd32, 64'd0});
    ack();

    // CT counter saturation near the 2^36-32 byte limit
    go(); cb(16);
    force dut.u_ct_cnt.cnt_q = 61'hF_FFFF_FFD8;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    release dut.u_ct_cnt.cnt_q;
    cb(16); fin();
    cmp("sat_err", {127'd0, err}, 128'd1);
    cmp("sat_block", len_block, {64'd0, 64'h0000_007F_FFFF_FF00});
    ack();

    // Asynchronous reset mid-CT with consumer ready
    go(); cb(16); cb(16);
    len_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_valid", {127'd0, len_valid}, 128'd0);
    cmp("arst_busy", {127'd0, busy}, 128'd0);
    cmp("arst_err", {127'd0, err}, 128'd0);
    cmp("arst_block", len_block, 128'd0);
    @(negedge clk); rst_n = 1'b1; len_ready = 1'b0;
    @(posedge clk); #1;
    go(); fin();
    cmp("post_rst_valid", {127'd0, len_valid}, 128'd1);
    cmp("post_rst_block", len_block, 128'd0);
    ack();
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gcm_len_tracker.md
GCM_LEN_TRACKER -- requirements
Module: gcm_len_tracker

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 16, meaning bytes per data beat; legal values are 4, 8 or 16.
REQ-002 SHALL have parameter LEN_W, default 64, meaning width of each length field in bits; legal values are 32 to 64.
REQ-003 SHALL have parameter CT_MAX_BYTES, default 2^36-32, meaning the SP 800-38D limit on plaintext/ciphertext length.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin a new message; clears both counters.
REQ-007 SHALL have port aad_valid, input, 1 bit: one AAD beat is present this cycle.
REQ-008 SHALL have port ct_valid, input, 1 bit: one CT beat is present this cycle.
REQ-009 SHALL have port beat_bytes, input, $clog2(BEAT_BYTES)+1 bits: valid bytes in the current beat, range 1..BEAT_BYTES.
REQ-010 SHALL have port finish, input, 1 bit: message complete; request the length block.
REQ-011 SHALL have port len_valid, output, 1 bit: len_block is valid.
REQ-012 SHALL have port len_ready, input, 1 bit: the GHASH consumer accepts len_block.
REQ-013 SHALL have port len_block, output, 2*LEN_W bits: {aad_bits, ct_bits}, each LEN_W bits wide, big-endian.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port err, output, 1 bit: sticky protocol/limit error, cleared only by start or reset.

Function
REQ-016 SHALL implement states IDLE, AAD, CT, EMIT.
REQ-017 In IDLE, start SHALL zero the counters, clear err and go to AAD; all other inputs in IDLE SHALL be ignored.
REQ-018 In AAD, aad_valid SHALL add beat_bytes to aad_cnt; ct_valid SHALL add beat_bytes to ct_cnt and move to CT.
REQ-019 In CT, ct_valid SHALL add beat_bytes to ct_cnt; aad_valid SHALL set err, and aad_cnt SHALL stay unchanged.
REQ-020 A beat with beat_bytes < BEAT_BYTES SHALL close its phase; any later beat of the same type SHALL set err and not be counted.
REQ-021 aad_valid and ct_valid high in the same cycle SHALL set err, and neither beat SHALL be counted.
REQ-022 beat_bytes of 0 or greater than BEAT_BYTES with a valid SHALL set err, and the beat SHALL not be counted.
REQ-023 ct_cnt exceeding CT_MAX_BYTES, or aad_cnt exceeding 2^(LEN_W-3)-1 bytes, SHALL set err; the counter SHALL saturate at its maximum and not wrap.
REQ-024 finish in AAD or CT SHALL go to EMIT the next cycle; a beat in the same cycle as finish SHALL be counted first.
REQ-025 In EMIT, len_valid SHALL be 1 and len_block SHALL be {aad_cnt<<3, ct_cnt<<3}, held stable until len_valid && len_ready.
REQ-026 The handshake in EMIT SHALL return the block to IDLE in the next cycle; latency from finish to len_valid SHALL be exactly 1 cycle.
REQ-027 In EMIT, data beats and finish SHALL be ignored, and start SHALL be ignored until the handshake completes.
REQ-028 start in AAD or CT SHALL abort the message, zero the counters, clear err and stay in/enter AAD.
REQ-029 err SHALL NOT block EMIT; the consumer samples err together with len_valid.
REQ-030 An empty message (start then finish) SHALL emit len_block = 0.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, aad_cnt=0, ct_cnt=0, len_valid=0, busy=0, err=0, len_block=0 and clear the phase-closed flags.
REQ-032 Reset deassertion SHALL be synchronised externally; the first active edge after release SHALL be treated as IDLE.

Structure
REQ-033 The state enum, BEAT_BYTES legal values and the default CT_MAX_BYTES SHALL live in shared package gcm_pkg.
REQ-034 The saturating byte counter with overflow flag SHALL be a sub-module, gcm_sat_cnt, instantiated twice (AAD and CT).
REQ-035 len_block SHALL be driven from registers, with no combinational path from inputs to len_block or len_valid.

Verification
REQ-036 start; 2 AAD beats of 16 bytes; 1 AAD beat of 4 bytes; 3 CT beats of 16 bytes; finish -> len_block = {64'd288, 64'd384}, err=0.
REQ-037 start; finish -> len_valid one cycle later, len_block=0; hold len_ready=0 for 5 cycles -> block stable, then IDLE after the handshake.
REQ-038 start; CT beat of 16 bytes; AAD beat -> err=1, aad_bits=0, ct_bits=128 at EMIT.
REQ-039 start; AAD beat of 8 bytes, then AAD beat of 16 bytes -> err=1, aad_bits=64.
REQ-040 Preload ct_cnt near CT_MAX_BYTES via a force; one CT beat of 16 bytes -> saturates, err=1, no wrap.
REQ-041 rst_n pulsed low mid-CT with len_ready=1 -> all outputs 0 immediately, then start/finish -> len_block=0.
